// File: rtl/meta_chooser.sv
// Tournament chooser: per-entry saturating counters pick global vs local predictor; table swept to INIT_VAL after reset.
// Latency: lookup registered, 1 cycle; no backpressure (updates always accepted in RUN, dropped during the init sweep).
module meta_chooser #(
  parameter int IDX_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 10,
  parameter int HASH_MODE = 0,
  parameter int INIT_VAL  = 2**(CTR_BITS-1)-1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_input,
  input  logic [31:0] Instr_addr_input,
  input  logic        Upd_valid,
  input  logic [31:0] Upd_addr,
  input  logic        Upd_global_correct,
  input  logic        Upd_local_correct,
  input  logic        Upd_taken,
  output logic        Use_global,
  output logic        Pred_is_branch,
  output logic        Ready
);

  localparam int DEPTH = 2**IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_VAL);
  localparam logic [IDX_BITS-1:0] PTR_LAST = IDX_BITS'(DEPTH-1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   ptr_q, ptr_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic                  use_global_q, use_global_d;
  logic                  is_branch_q, is_branch_d;
  logic                  ready_q, ready_d;

  logic [CTR_BITS-1:0]   ctr_mem [DEPTH];

  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [CTR_BITS-1:0]   wr_dat;

  logic [IDX_BITS-1:0]   lk_idx, up_idx;
  logic [CTR_BITS-1:0]   lk_ctr, up_ctr;
  logic                  lk_branch;
  logic [HIST_BITS:0]    ghr_ext;
  logic                  unused_ok;

  function automatic logic is_cond_branch(input logic [31:0] instr);
    logic [5:0] opcode;
    logic [4:0] rt;
    opcode = instr[31:26];
    rt     = instr[20:16];
    case (opcode)
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cond_branch = 1'b1;
      6'b000001: is_cond_branch = (rt == 5'b00000) || (rt == 5'b00001) ||
                                  (rt == 5'b10000) || (rt == 5'b10001);
      default:   is_cond_branch = 1'b0;
    endcase
  endfunction

  // gshare: history is zero-extended into the low index bits
  function automatic logic [IDX_BITS-1:0] calc_idx(input logic [31:0] addr,
                                                   input logic [HIST_BITS-1:0] ghr);
    logic [IDX_BITS-1:0] base;
    base = addr[IDX_BITS+1:2];
    if (HASH_MODE != 0) base = base ^ IDX_BITS'(ghr);
    calc_idx = base;
  endfunction

  assign lk_idx    = calc_idx(Instr_addr_input, ghr_q);
  assign up_idx    = calc_idx(Upd_addr, ghr_q);
  assign lk_ctr    = ctr_mem[lk_idx];
  assign up_ctr    = ctr_mem[up_idx];
  assign lk_branch = is_cond_branch(Instr_input);
  assign ghr_ext   = {ghr_q, Upd_taken};

  assign unused_ok = ^{Instr_addr_input[31:IDX_BITS+2], Instr_addr_input[1:0],
                       Upd_addr[31:IDX_BITS+2], Upd_addr[1:0], ghr_ext[HIST_BITS]};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ghr_d        = ghr_q;
    use_global_d = use_global_q;
    is_branch_d  = is_branch_q;
    ready_d      = ready_q;
    wr_en        = 1'b0;
    wr_idx       = ptr_q;
    wr_dat       = CTR_INIT;

    case (state_q)
      ST_INIT: begin
        wr_en        = 1'b1;
        wr_idx       = ptr_q;
        wr_dat       = CTR_INIT;
        use_global_d = 1'b1;
        is_branch_d  = 1'b0;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + IDX_BITS'(1);
        end
      end

      ST_RUN: begin
        // Lookup reads the pre-write table, so a same-index update is not visible yet
        is_branch_d  = lk_branch;
        use_global_d = lk_branch ? lk_ctr[CTR_BITS-1] : 1'b1;
        if (Upd_valid) begin
          ghr_d  = ghr_ext[HIST_BITS-1:0];
          wr_idx = up_idx;
          if (Upd_global_correct && !Upd_local_correct && (up_ctr != CTR_MAX)) begin
            wr_en  = 1'b1;
            wr_dat = up_ctr + CTR_BITS'(1);
          end else if (Upd_local_correct && !Upd_global_correct && (up_ctr != '0)) begin
            wr_en  = 1'b1;
            wr_dat = up_ctr - CTR_BITS'(1);
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      ghr_q        <= '0;
      use_global_q <= 1'b1;
      is_branch_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ghr_q        <= ghr_d;
      use_global_q <= use_global_d;
      is_branch_q  <= is_branch_d;
      ready_q      <= ready_d;
    end
  end

  // Table is not reset; the init sweep rewrites every entry instead
  always_ff @(posedge CLK) begin
    if (wr_en) ctr_mem[wr_idx] <= wr_dat;
  end

  assign Use_global     = use_global_q;
  assign Pred_is_branch = is_branch_q;
  assign Ready          = ready_q;

endmodule

// File: tb/tb_meta_chooser.sv
// Bench for meta_chooser: plain and gshare-hashed instances share stimulus and are checked against an array model.
module tb_meta_chooser;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_input, Instr_addr_input, Upd_addr;
  logic        Upd_valid, Upd_global_correct, Upd_local_correct, Upd_taken;
  logic        use0, br0, rdy0, use1, br1, rdy1;

  always #5 CLK = ~CLK;

  meta_chooser #(.HASH_MODE(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .Instr_input(Instr_input), .Instr_addr_input(Instr_addr_input),
    .Upd_valid(Upd_valid), .Upd_addr(Upd_addr), .Upd_global_correct(Upd_global_correct),
    .Upd_local_correct(Upd_local_correct), .Upd_taken(Upd_taken),
    .Use_global(use0), .Pred_is_branch(br0), .Ready(rdy0));

  meta_chooser #(.HASH_MODE(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .Instr_input(Instr_input), .Instr_addr_input(Instr_addr_input),
    .Upd_valid(Upd_valid), .Upd_addr(Upd_addr), .Upd_global_correct(Upd_global_correct),
    .Upd_local_correct(Upd_local_correct), .Upd_taken(Upd_taken),
    .Use_global(use1), .Pred_is_branch(br1), .Ready(rdy1));

  int errors = 0;
  int checks = 0;

  // Reference: counters per index for each hashing mode, plus history as an integer
  int ctr_m0 [1024];
  int ctr_m1 [1024];
  int ghr_m;

  typedef struct {
    logic [31:0] instr;
    logic        uv;
    logic        gc;
    logic        lc;
    logic        tk;
    logic        eu;
    logic        eb;
  } vec_t;

  vec_t tbl [31];

  logic [31:0] instr_pool [10];
  logic [31:0] addr_pool  [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_is_branch(input logic [31:0] instr);
    int op, rt;
    op = int'(instr >> 26) & 63;
    rt = int'(instr >> 16) & 31;
    if (op >= 4 && op <= 7) return 1'b1;
    if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_idx(input logic [31:0] addr, input int hashed);
    int base;
    base = int'(addr >> 2) % 1024;
    return hashed != 0 ? (base ^ ghr_m) : base;
  endfunction

  function automatic int trained(input int c, input logic gc, input logic lc);
    if (gc && !lc) return (c < 3) ? c + 1 : c;
    if (lc && !gc) return (c > 0) ? c - 1 : c;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      ctr_m0[i] = 1;
      ctr_m1[i] = 1;
    end
    ghr_m = 0;
  endtask

  task automatic drive_random();
    Instr_input        = ($urandom_range(0, 3) == 0) ? $urandom() : instr_pool[$urandom_range(0, 9)];
    Instr_addr_input   = addr_pool[$urandom_range(0, 4)];
    Upd_valid          = 1'($urandom_range(0, 1));
    Upd_addr           = addr_pool[$urandom_range(0, 4)];
    Upd_global_correct = 1'($urandom_range(0, 1));
    Upd_local_correct  = 1'($urandom_range(0, 1));
    Upd_taken          = 1'($urandom_range(0, 1));
  endtask

  // One clock: drive, predict from model pre-state, step model, compare after the edge
  task automatic cycle(input logic [31:0] instr, input logic [31:0] addr, input logic uv,
                       input logic [31:0] uaddr, input logic gc, input logic lc, input logic tk,
                       input bit use_tbl, input logic tu, input logic tb, input string tag);
    bit eb;
    int e0, e1, i0, i1;
    Instr_input = instr; Instr_addr_input = addr; Upd_valid = uv; Upd_addr = uaddr;
    Upd_global_correct = gc; Upd_local_correct = lc; Upd_taken = tk;
    eb = model_is_branch(instr);
    i0 = model_idx(addr, 0);
    i1 = model_idx(addr, 1);
    e0 = eb ? int'(ctr_m0[i0] >= 2) : 1;
    e1 = eb ? int'(ctr_m1[i1] >= 2) : 1;
    if (uv) begin
      i0 = model_idx(uaddr, 0);
      i1 = model_idx(uaddr, 1);
      ctr_m0[i0] = trained(ctr_m0[i0], gc, lc);
      ctr_m1[i1] = trained(ctr_m1[i1], gc, lc);
      ghr_m = ((ghr_m << 1) | int'(tk)) % 1024;
    end
    @(posedge CLK); #1;
    check({tag, " use0"}, 32'(use0), 32'(e0));
    check({tag, " br0"},  32'(br0),  32'(eb));
    check({tag, " use1"}, 32'(use1), 32'(e1));
    check({tag, " br1"},  32'(br1),  32'(eb));
    if (use_tbl) begin
      check({tag, " tbl_use"}, 32'(use0), 32'(tu));
      check({tag, " tbl_br"},  32'(br0),  32'(tb));
    end
  endtask

  // Counts edges from release until Ready; outputs must stay at idle values meanwhile
  task automatic wait_ready(input string tag);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    do begin
      drive_random();
      @(posedge CLK); #1;
      n++;
      if (!(use0 === 1'b1 && br0 === 1'b0 && use1 === 1'b1 && br1 === 1'b0)) bad = 1'b1;
    end while (rdy0 !== 1'b1 && n < 2000);
    check({tag, " ready_edges"}, 32'(n), 32'd1024);
    check({tag, " ready1"}, 32'(rdy1), 32'd1);
    check({tag, " init_outputs_idle"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " use0"}, 32'(use0), 32'd1);
    check({tag, " br0"},  32'(br0),  32'd0);
    check({tag, " rdy0"}, 32'(rdy0), 32'd0);
    check({tag, " use1"}, 32'(use1), 32'd1);
    check({tag, " br1"},  32'(br1),  32'd0);
    check({tag, " rdy1"}, 32'(rdy1), 32'd0);
  endtask

  localparam logic [31:0] BEQ = 32'h1000_0000;
  localparam logic [31:0] PC  = 32'h0000_0400;

  initial begin
    tbl = '{
      '{BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{BEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{32'h0411_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h0400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h0402_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{32'h1400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h1800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h1C00_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{32'h0410_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{32'h0401_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}
    };
    instr_pool = '{BEQ, 32'h1400_0000, 32'h1800_0000, 32'h1C00_0000, 32'h0411_0000,
                   32'h0400_0000, 32'h0403_0000, 32'h0000_0020, 32'h0800_0000, 32'h0401_0000};
    // 0x2400 aliases 0x400 in the plain index
    addr_pool  = '{PC, 32'h0000_0404, 32'h0000_1000, 32'h0000_2400, 32'h0000_0BFC};

    RESET = 1'b0;
    Instr_input = '0; Instr_addr_input = '0; Upd_valid = 1'b0; Upd_addr = '0;
    Upd_global_correct = 1'b0; Upd_local_correct = 1'b0; Upd_taken = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");

    // Abort the sweep at pointer 500 and restart it
    @(negedge CLK); RESET = 1'b1;
    for (int i = 0; i < 500; i++) begin
      drive_random();
      @(posedge CLK); #1;
    end
    #3 RESET = 1'b0;
    #1 check_reset_values("reset_mid_init");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    wait_ready("init1");

    for (int i = 0; i < 31; i++)
      cycle(tbl[i].instr, PC, tbl[i].uv, PC, tbl[i].gc, tbl[i].lc, tbl[i].tk,
            1'b1, tbl[i].eu, tbl[i].eb, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      drive_random();
      cycle(Instr_input, Instr_addr_input, Upd_valid, Upd_addr, Upd_global_correct,
            Upd_local_correct, Upd_taken, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // Drive the 0x400 entry to zero, then reset while RUN shows a branch prediction
    for (int i = 0; i < 3; i++)
      cycle(BEQ, PC, 1'b1, PC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "drain");
    cycle(BEQ, PC, 1'b0, PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "pre_reset");
    #3 RESET = 1'b0;
    #1 check_reset_values("reset_mid_run");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    wait_ready("init2");

    // Entry back at 1: same-edge train reads 0, next lookup reads 1
    cycle(BEQ, PC, 1'b1, PC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "post_reset_a");
    cycle(BEQ, PC, 1'b0, PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "post_reset_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
